// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the fetch/decode front end.
// Pure declarations: no logic, no latency.
package pipe_pkg;

  localparam int I = 24;
  localparam int P = 16;
  localparam logic [P-1:0] RESET_PC = '0;
  localparam logic [I-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port plus IF/ID outputs and decode/redirect controls.
// master = fetch stage side; slave = memory/decode side.
interface fetch_stage_if #(
  parameter int I = pipe_pkg::I,
  parameter int P = pipe_pkg::P
);

  logic         imem_req_o;
  logic [P-1:0] imem_addr_o;
  logic         imem_ack_i;
  logic [I-1:0] imem_rdata_i;
  logic         stall_i;
  logic         br_take_i;
  logic [P-1:0] br_target_i;
  logic [I-1:0] instr_o;
  logic [P-1:0] next_pc_o;
  logic         valid_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_o, next_pc_o, valid_o,
    input  imem_ack_i, imem_rdata_i, stall_i, br_take_i, br_target_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, next_pc_o, valid_o,
    output imem_ack_i, imem_rdata_i, stall_i, br_take_i, br_target_i
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > load > bubble > hold, one-cycle latency.
// Holds contents whenever no control is active, which is how stall is applied.
module if_id_reg #(
  parameter int I = pipe_pkg::I,
  parameter int P = pipe_pkg::P
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic         bubble,
  input  logic [I-1:0] instr_d,
  input  logic [P-1:0] npc_d,
  output logic [I-1:0] instr_q,
  output logic [P-1:0] npc_q,
  output logic         valid_q
);
  import pipe_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= I'(NOP_INSTR);
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= I'(NOP_INSTR);
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= 1'b1;
    end else if (bubble) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem FSM, skid buffer and IF/ID register.
// One instr/cycle with 0-wait memory; stall parks an arrived word in the skid buffer.
module fetch_stage #(
  parameter int           I        = pipe_pkg::I,
  parameter int           P        = pipe_pkg::P,
  parameter logic [P-1:0] RESET_PC = P'(pipe_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  fetch_stage_if.master    bus
);
  import pipe_pkg::*;

  fetch_state_t state, state_n;
  logic [P-1:0] pc, pc_n, pc_inc;
  logic [P-1:0] drain_addr, drain_n;
  logic [I-1:0] skid_instr;
  logic [P-1:0] skid_npc;
  logic         skid_ld;
  logic         ifid_load, ifid_flush, ifid_bubble, ifid_from_skid;
  logic [I-1:0] ifid_instr_d;
  logic [P-1:0] ifid_npc_d;

  assign pc_inc = pc + P'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      drain_addr <= '0;
      skid_instr <= '0;
      skid_npc   <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drain_addr <= drain_n;
      if (bus.br_take_i) begin
        skid_instr <= '0;
        skid_npc   <= '0;
      end else if (skid_ld) begin
        skid_instr <= bus.imem_rdata_i;
        skid_npc   <= pc_inc;
      end
    end
  end

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    drain_n        = drain_addr;
    skid_ld        = 1'b0;
    ifid_load      = 1'b0;
    ifid_flush     = 1'b0;
    ifid_bubble    = 1'b0;
    ifid_from_skid = 1'b0;
    if (bus.br_take_i) begin
      ifid_flush = 1'b1;
      pc_n       = bus.br_target_i;
      case (state)
        // An unacknowledged request must still complete before the new address is issued.
        REQ: begin
          if (bus.imem_ack_i) begin
            state_n = REQ;
          end else begin
            drain_n = pc;
            state_n = DRAIN;
          end
        end
        HOLD:    state_n = REQ;
        default: state_n = DRAIN;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (bus.imem_ack_i) begin
            pc_n = pc_inc;
            if (bus.stall_i) begin
              skid_ld = 1'b1;
              state_n = HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end else if (!bus.stall_i) begin
            ifid_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!bus.stall_i) begin
            ifid_load      = 1'b1;
            ifid_from_skid = 1'b1;
            state_n        = REQ;
          end
        end
        default: begin
          ifid_bubble = 1'b1;
          if (bus.imem_ack_i) state_n = REQ;
        end
      endcase
    end
  end

  assign ifid_instr_d    = ifid_from_skid ? skid_instr : bus.imem_rdata_i;
  assign ifid_npc_d      = ifid_from_skid ? skid_npc   : pc_inc;
  assign bus.imem_req_o  = !rst && (state != HOLD);
  assign bus.imem_addr_o = (state == DRAIN) ? drain_addr : pc;

  if_id_reg #(.I(I), .P(P)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .bubble  (ifid_bubble),
    .instr_d (ifid_instr_d),
    .npc_d   (ifid_npc_d),
    .instr_q (bus.instr_o),
    .npc_q   (bus.next_pc_o),
    .valid_q (bus.valid_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/HOLD, redirect, DRAIN, PC wrap, async reset.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  int   wait_n;
  logic [3:0] cnt;

  fetch_stage_if #(.I(24), .P(16)) f0 ();
  fetch_stage_if #(.I(24), .P(16)) f1 ();

  fetch_stage #(.I(24), .P(16), .RESET_PC(16'h0000)) dut0 (.clk(clk), .rst(rst), .bus(f0.master));
  fetch_stage #(.I(24), .P(16), .RESET_PC(16'hFFFE)) dut1 (.clk(clk), .rst(rst), .bus(f1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory for dut0: acknowledges after wait_n cycles of a pending request
  assign f0.imem_ack_i   = f0.imem_req_o && (int'(cnt) >= wait_n);
  assign f0.imem_rdata_i = 24'h000E59 + {8'h00, f0.imem_addr_o};
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (!f0.imem_req_o || f0.imem_ack_i) cnt <= '0;
    else cnt <= cnt + 4'd1;
  end

  assign f1.imem_ack_i   = f1.imem_req_o;
  assign f1.imem_rdata_i = 24'h000E59 + {8'h00, f1.imem_addr_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ifid(input string tag, input logic [23:0] ins, input logic [15:0] npc, input logic v);
    chk({tag, "_valid"}, 32'(f0.valid_o), 32'(v));
    chk({tag, "_instr"}, 32'(f0.instr_o), 32'(ins));
    chk({tag, "_npc"}, 32'(f0.next_pc_o), 32'(npc));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    wait_n   = 0;
    rst      = 1'b1;
    f0.stall_i = 1'b0; f0.br_take_i = 1'b0; f0.br_target_i = '0;
    f1.stall_i = 1'b0; f1.br_take_i = 1'b0; f1.br_target_i = '0;

    @(negedge clk);
    chk_ifid("reset", 24'h0, 16'h0, 1'b0);
    chk("reset_req", 32'(f0.imem_req_o), 32'd0);
    chk("reset_req1", 32'(f1.imem_req_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("start_req", 32'(f0.imem_req_o), 32'd1);
    chk("start_addr", 32'(f0.imem_addr_o), 32'h0);
    chk("start_addr1", 32'(f1.imem_addr_o), 32'hFFFE);

    // 0-wait stream, and the wrapping stream from 0xFFFE on dut1
    tick();
    chk_ifid("s0", 24'h000E59, 16'd1, 1'b1);
    chk("wrap0", 32'(f1.next_pc_o), 32'hFFFF);
    chk("wrap0_v", 32'(f1.valid_o), 32'd1);
    tick();
    chk_ifid("s1", 24'h000E5A, 16'd2, 1'b1);
    chk("wrap1", 32'(f1.next_pc_o), 32'h0000);
    tick();
    chk_ifid("s2", 24'h000E5B, 16'd3, 1'b1);
    chk("wrap2", 32'(f1.next_pc_o), 32'h0001);
    tick();
    chk_ifid("s3", 24'h000E5C, 16'd4, 1'b1);
    chk("s3_addr", 32'(f0.imem_addr_o), 32'd4);

    // stall while addr 4 is acknowledged
    f0.stall_i = 1'b1;
    tick();
    chk("hold_req", 32'(f0.imem_req_o), 32'd0);
    chk_ifid("hold0", 24'h000E5C, 16'd4, 1'b1);
    tick();
    chk_ifid("hold1", 24'h000E5C, 16'd4, 1'b1);
    tick();
    chk_ifid("hold2", 24'h000E5C, 16'd4, 1'b1);
    f0.stall_i = 1'b0;
    tick();
    chk_ifid("release", 24'h000E5D, 16'd5, 1'b1);
    chk("release_addr", 32'(f0.imem_addr_o), 32'd5);
    tick();
    chk_ifid("after_rel", 24'h000E5E, 16'd6, 1'b1);

    // redirect during 0-wait stream
    f0.br_take_i = 1'b1; f0.br_target_i = 16'h002A;
    tick();
    f0.br_take_i = 1'b0;
    chk_ifid("flush", 24'h0, 16'h0, 1'b0);
    chk("redir_addr", 32'(f0.imem_addr_o), 32'h2A);
    tick();
    chk_ifid("target", 24'h000E83, 16'h002B, 1'b1);

    // 3-wait memory, redirect in the first wait cycle -> DRAIN
    wait_n = 3;
    f0.br_take_i = 1'b1; f0.br_target_i = 16'h0100;
    #1;
    chk("wait1_ack", 32'(f0.imem_ack_i), 32'd0);
    tick();
    f0.br_take_i = 1'b0;
    chk("drain0_addr", 32'(f0.imem_addr_o), 32'h2B);
    chk("drain0_req", 32'(f0.imem_req_o), 32'd1);
    chk("drain0_v", 32'(f0.valid_o), 32'd0);
    tick();
    chk("drain1_addr", 32'(f0.imem_addr_o), 32'h2B);
    chk("drain1_v", 32'(f0.valid_o), 32'd0);
    tick();
    chk("drain2_addr", 32'(f0.imem_addr_o), 32'h2B);
    chk("drain2_ack", 32'(f0.imem_ack_i), 32'd1);
    chk("drain2_v", 32'(f0.valid_o), 32'd0);
    tick();
    chk("post_drain_addr", 32'(f0.imem_addr_o), 32'h100);
    chk("post_drain_v", 32'(f0.valid_o), 32'd0);
    wait_n = 0;
    tick();
    chk_ifid("t100", 24'h000F59, 16'h0101, 1'b1);

    // async reset while in HOLD
    f0.stall_i = 1'b1;
    tick();
    chk("hold_req2", 32'(f0.imem_req_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk_ifid("rst_hold", 24'h0, 16'h0, 1'b0);
    chk("rst_hold_req", 32'(f0.imem_req_o), 32'd0);
    chk("rst_hold_addr", 32'(f0.imem_addr_o), 32'h0);
    f0.stall_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("restart_req", 32'(f0.imem_req_o), 32'd1);
    chk("restart_addr", 32'(f0.imem_addr_o), 32'h0);
    tick();
    chk_ifid("restart", 24'h000E59, 16'd1, 1'b1);

    // async reset while in DRAIN
    wait_n = 3;
    f0.br_take_i = 1'b1; f0.br_target_i = 16'h0050;
    tick();
    f0.br_take_i = 1'b0;
    chk("drain_b_addr", 32'(f0.imem_addr_o), 32'h1);
    chk("drain_b_v", 32'(f0.valid_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk_ifid("rst_drain", 24'h0, 16'h0, 1'b0);
    chk("rst_drain_req", 32'(f0.imem_req_o), 32'd0);
    chk("rst_drain_addr", 32'(f0.imem_addr_o), 32'h0);
    wait_n = 0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_ifid("restart2", 24'h000E59, 16'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
